// File: rtl/jb_pkg.sv
// Encodings and FSM states shared by the PC redirect controller and its
// branch-condition helper.
package jb_pkg;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JR   = 2'b10,
    JMP_SEQ  = 2'b11
  } jump_e;

  typedef enum logic [1:0] {
    BOP_NONE = 2'b00,
    BOP_RSV  = 2'b01,
    BOP_BNE  = 2'b10,
    BOP_BEQ  = 2'b11
  } bop_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_REG = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_BR_RESOLVE = 2'b01,
    ST_JR_WAIT    = 2'b10,
    ST_REDIRECT   = 2'b11
  } state_e;

  localparam logic [15:0] REDIRECT_MAX = 16'hFFFF;

  function automatic logic is_branch(input logic [1:0] bop);
    return (bop == BOP_BNE) || (bop == BOP_BEQ);
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Branch outcome from the latched branch op and the execute-stage compare.
module br_cond_eval
  import jb_pkg::*;
(
  input  logic [1:0] bop,
  input  logic       eq,
  output logic       taken
);

  assign taken = ((bop == BOP_BEQ) &&  eq) ||
                 ((bop == BOP_BNE) && !eq);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC redirect control: jumps, register jumps with hazard wait,
// one-cycle-latency branches, and a saturating redirect counter.
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_RUN        | normal decode; jumps redirect combinationally
// ST_BR_RESOLVE | branch latched, execute compare decides taken/not taken
// ST_JR_WAIT    | jr source not forwardable yet, PC and IF/ID held
// ST_REDIRECT   | redirect issued but imem not ready; select held
module pc_redirect_ctrl
  import jb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [1:0]  i_jump,
  input  logic [1:0]  i_bop,
  input  logic        i_eq,
  input  logic        i_jr_hazard,
  input  logic        i_imem_ready,
  output logic [1:0]  o_pc_sel,
  output logic        o_flush_fd,
  output logic        o_stall,
  output logic        o_illegal,
  output logic [15:0] o_redirects
);

  state_e      state_q, state_d;
  pc_sel_e     sel_q, sel_d, pc_sel;
  logic [1:0]  bop_q, bop_d;
  logic        flush, stall, illegal;
  logic        br_taken;
  logic [15:0] redirects_q;

  br_cond_eval u_br_cond_eval (
    .bop   (bop_q),
    .eq    (i_eq),
    .taken (br_taken)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      sel_q   <= PC_SEQ;
      bop_q   <= BOP_NONE;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bop_q   <= bop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    bop_d   = bop_q;
    pc_sel  = PC_SEQ;
    flush   = 1'b0;
    stall   = 1'b0;
    illegal = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (i_valid) begin
          // jumps win over any branch op decoded alongside them
          if ((i_jump == JMP_J) || ((i_jump == JMP_JR) && !i_jr_hazard)) begin
            pc_sel = (i_jump == JMP_J) ? PC_JMP : PC_REG;
            flush  = 1'b1;
            if (!i_imem_ready) begin
              sel_d   = pc_sel;
              state_d = ST_REDIRECT;
            end
          end else if (i_jump == JMP_JR) begin
            stall   = 1'b1;
            state_d = ST_JR_WAIT;
          end else if (is_branch(i_bop)) begin
            bop_d   = i_bop;
            stall   = 1'b1;
            state_d = ST_BR_RESOLVE;
          end else if (i_bop == BOP_RSV) begin
            illegal = 1'b1;
          end
        end
      end

      ST_BR_RESOLVE: begin
        bop_d = BOP_NONE;
        if (br_taken) begin
          pc_sel = PC_BR;
          flush  = 1'b1;
          if (!i_imem_ready) begin
            sel_d   = PC_BR;
            state_d = ST_REDIRECT;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_JR_WAIT: begin
        if (i_jr_hazard) begin
          stall = 1'b1;
        end else begin
          pc_sel = PC_REG;
          flush  = 1'b1;
          if (!i_imem_ready) begin
            sel_d   = PC_REG;
            state_d = ST_REDIRECT;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_REDIRECT: begin
        pc_sel = sel_q;
        flush  = 1'b1;
        stall  = !i_imem_ready;
        if (i_imem_ready) begin
          state_d = ST_RUN;
        end
      end
    endcase

    // reset also silences the combinational outputs so nothing leaks out
    if (i_rst) begin
      pc_sel  = PC_SEQ;
      flush   = 1'b0;
      stall   = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      redirects_q <= '0;
    end else if ((pc_sel != PC_SEQ) && i_imem_ready && (redirects_q != REDIRECT_MAX)) begin
      redirects_q <= redirects_q + 16'd1;
    end
  end

  assign o_pc_sel    = pc_sel;
  assign o_flush_fd  = flush;
  assign o_stall     = stall;
  assign o_illegal   = illegal;
  assign o_redirects = redirects_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with hand-computed expectations.
module tb_pc_redirect_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [1:0]  i_jump = 2'b00;
  logic [1:0]  i_bop = 2'b00;
  logic        i_eq = 1'b0;
  logic        i_jr_hazard = 1'b0;
  logic        i_imem_ready = 1'b1;
  logic [1:0]  o_pc_sel;
  logic        o_flush_fd;
  logic        o_stall;
  logic        o_illegal;
  logic [15:0] o_redirects;

  int n_checks = 0;
  int n_pass   = 0;

  pc_redirect_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_jump       (i_jump),
    .i_bop        (i_bop),
    .i_eq         (i_eq),
    .i_jr_hazard  (i_jr_hazard),
    .i_imem_ready (i_imem_ready),
    .o_pc_sel     (o_pc_sel),
    .o_flush_fd   (o_flush_fd),
    .o_stall      (o_stall),
    .o_illegal    (o_illegal),
    .o_redirects  (o_redirects)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // apply one cycle of inputs just after the edge, then let comb outputs settle
  task automatic cyc(input logic v, input logic [1:0] j, input logic [1:0] b,
                     input logic e, input logic h, input logic r);
    @(posedge i_clk);
    #1;
    i_valid = v; i_jump = j; i_bop = b; i_eq = e; i_jr_hazard = h; i_imem_ready = r;
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2;
    check("rst_pc_sel", o_pc_sel, 0);
    check("rst_flush", o_flush_fd, 0);
    check("rst_stall", o_stall, 0);
    check("rst_redirects", o_redirects, 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // non-control instruction
    cyc(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
    check("seq_pc_sel", o_pc_sel, 0);
    check("seq_flush", o_flush_fd, 0);
    check("seq_stall", o_stall, 0);
    idle();
    check("seq_redirects", o_redirects, 0);

    // beq taken
    cyc(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1);
    check("beq_stall", o_stall, 1);
    check("beq_stall_sel", o_pc_sel, 0);
    cyc(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    check("beq_taken_sel", o_pc_sel, 1);
    check("beq_taken_flush", o_flush_fd, 1);
    check("beq_taken_stall", o_stall, 0);
    idle();
    check("beq_redirects", o_redirects, 1);
    check("beq_after_sel", o_pc_sel, 0);

    // beq not taken
    cyc(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1);
    check("beqn_stall", o_stall, 1);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("beqn_sel", o_pc_sel, 0);
    check("beqn_flush", o_flush_fd, 0);

    // bne with equal operands: not taken
    cyc(1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1);
    check("bne_stall", o_stall, 1);
    cyc(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    check("bnen_sel", o_pc_sel, 0);
    check("bnen_flush", o_flush_fd, 0);
    idle();
    check("bnen_redirects", o_redirects, 1);

    // bne with unequal operands: taken
    cyc(1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("bnet_sel", o_pc_sel, 1);
    check("bnet_flush", o_flush_fd, 1);
    idle();
    check("bnet_redirects", o_redirects, 2);

    // jr with 3 hazard cycles
    cyc(1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1);
    check("jr_stall1", o_stall, 1);
    check("jr_stall1_sel", o_pc_sel, 0);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    check("jr_stall2", o_stall, 1);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    check("jr_stall3", o_stall, 1);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("jr_go_sel", o_pc_sel, 3);
    check("jr_go_flush", o_flush_fd, 1);
    check("jr_go_stall", o_stall, 0);
    idle();
    check("jr_done_sel", o_pc_sel, 0);
    check("jr_done_flush", o_flush_fd, 0);
    check("jr_redirects", o_redirects, 3);

    // jr without hazard
    cyc(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
    check("jrnh_sel", o_pc_sel, 3);
    check("jrnh_flush", o_flush_fd, 1);
    idle();
    check("jrnh_redirects", o_redirects, 4);

    // j with imem busy for 2 cycles
    cyc(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("jbusy_sel1", o_pc_sel, 2);
    check("jbusy_flush1", o_flush_fd, 1);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("jbusy_sel2", o_pc_sel, 2);
    check("jbusy_stall2", o_stall, 1);
    check("jbusy_cnt2", o_redirects, 4);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("jbusy_sel3", o_pc_sel, 2);
    check("jbusy_flush3", o_flush_fd, 1);
    idle();
    check("jbusy_done_sel", o_pc_sel, 0);
    check("jbusy_redirects", o_redirects, 5);

    // reserved branch op
    cyc(1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1);
    check("ill_pulse", o_illegal, 1);
    check("ill_sel", o_pc_sel, 0);
    check("ill_stall", o_stall, 0);
    idle();
    check("ill_clear", o_illegal, 0);

    // jump overrides a simultaneous beq
    cyc(1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1);
    check("jprio_sel", o_pc_sel, 2);
    check("jprio_stall", o_stall, 0);
    cyc(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    check("jprio_nobr_sel", o_pc_sel, 0);
    check("jprio_redirects", o_redirects, 6);

    // invalid instruction ignored
    cyc(1'b0, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1);
    check("inval_sel", o_pc_sel, 0);
    check("inval_stall", o_stall, 0);

    // reset while in BR_RESOLVE
    cyc(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1);
    check("brrst_stall", o_stall, 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_jump = 2'b00; i_bop = 2'b00; i_eq = 1'b1; i_rst = 1'b1;
    #2;
    check("brrst_sel", o_pc_sel, 0);
    check("brrst_flush", o_flush_fd, 0);
    check("brrst_stall0", o_stall, 0);
    check("brrst_redirects", o_redirects, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    cyc(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    check("brrst_run_sel", o_pc_sel, 0);
    check("brrst_run_flush", o_flush_fd, 0);

    // saturation: back-to-back accepted jumps
    @(posedge i_clk);
    #1;
    i_valid = 1'b1; i_jump = 2'b01; i_bop = 2'b00; i_eq = 1'b0; i_imem_ready = 1'b1;
    repeat (65534) @(posedge i_clk);
    #1 check("sat_fffe", o_redirects, 16'hFFFE);
    @(posedge i_clk);
    #1 check("sat_ffff", o_redirects, 16'hFFFF);
    repeat (3) @(posedge i_clk);
    #1 check("sat_hold", o_redirects, 16'hFFFF);
    i_valid = 1'b0; i_jump = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
